ram_port_scheduler: RTL and testbench
=====================================

Name: ram_port_scheduler

Overview:
Sequences the shared SDRAM command controller between two requesters and the refresh engine. Port 0 is the Zorro II slave path; port 1 is the on-card IDE/DMA buffer path. Refresh intervals are counted locally and owed refreshes are banked. Refreshes are slotted into idle gaps, and forced ahead of clients once the backlog limit is reached. Sits between the bus-cycle decoders and the SDRAM command sequencer.

Parameters:
REFRESH_INTERVAL, 50, CLK cycles per owed refresh (about 7 us at 7.09 MHz); must be >= 2.
MAX_PENDING, 4, refresh backlog at which refresh preempts clients; range 1-7.

Ports:
CLK  in  1  system clock, all logic on rising edge
RESET_n  in  1  asynchronous active-low reset
req0 / req1  in  1  request from port 0 / port 1, level, held until doneN
addr0 / addr1  in  23  word address [23:1]
rw0 / rw1  in  1  1 = read, 0 = write
uds0_n, lds0_n / uds1_n, lds1_n  in  1 each  byte strobes, active low
grant0 / grant1  out  1  port owns the controller (grant through done)
done0 / done1  out  1  one-cycle pulse: transaction complete
mem_req  out  1  request to SDRAM sequencer, held until mem_ack
mem_refresh  out  1  1 = current request is an auto-refresh
mem_addr  out  23  latched address
mem_rw  out  1  latched direction
mem_uds_n, mem_lds_n  out  1 each  latched strobes
mem_ack  in  1  sequencer accepted the request (one-cycle pulse)
mem_done  in  1  sequencer finished, precharge complete (one-cycle pulse)
refresh_pending  out  3  owed refresh count
refresh_overrun  out  1  sticky: an interval tick was lost at saturation

Behaviour:
- Reset values:
  - grants, dones, mem_req, mem_refresh, refresh_overrun = 0.
  - mem_addr = 0; mem_rw, mem_uds_n, mem_lds_n = 1.
  - refresh_pending = 0; interval counter = REFRESH_INTERVAL-1.
  - state = IDLE; last_grant = 1, so port 0 wins the first tie.
- Interval counter:
  - Decrements every CLK.
  - At 0 it reloads REFRESH_INTERVAL-1 and issues a tick.
  - A tick increments refresh_pending.
  - If refresh_pending == MAX_PENDING at a tick, the tick is dropped and refresh_overrun sets. Only reset clears it.
  - mem_ack while mem_refresh = 1 decrements refresh_pending.
  - Tick and refresh ack in the same cycle: count unchanged.
- State machine:
  - IDLE, one decision per cycle, in priority order:
    - (a) refresh_pending == MAX_PENDING -> refresh.
    - (b) any eligible reqN -> client. If both are eligible, grant the port != last_grant (round-robin).
    - (c) refresh_pending > 0 -> refresh.
    - (d) otherwise stay in IDLE.
  - Entering ISSUE for a client:
    - Latch addr/rw/strobes of the winner into mem_*.
    - Set mem_refresh = 0, set grantN, update last_grant.
  - Entering ISSUE for a refresh: mem_refresh = 1, no grant, mem_* payload keeps its previous values.
  - ISSUE: mem_req = 1 until mem_ack is sampled. On mem_ack: mem_req = 0 next cycle, go to WAIT_DONE.
  - WAIT_DONE: on mem_done:
    - Pulse doneN for one cycle and drop grantN in that same cycle.
    - Clear mem_refresh, return to IDLE.
  - mem_done before mem_ack, or while in IDLE, is ignored.
- Latency: req sampled in IDLE -> grant and mem_req asserted on the next edge (one cycle).
- Client handshake:
  - The latched payload is frozen for the whole transaction; input changes after the grant are ignored.
  - Deasserting reqN after its grant does not abort the transaction; done still pulses.
  - A port is ineligible in the IDLE cycle immediately following its done pulse. This gives the requester one cycle to drop req without a spurious re-grant.
- Exclusivity: at most one of grant0, grant1, mem_refresh is ever high.
- Reset mid-operation: all state returns to reset values asynchronously; any in-flight transaction is abandoned without a done pulse.

Test Plan:
- Single read, port 0:
  - Stimulus: req0 = 1, addr0 = 0x123456, rw0 = 1; ack at +2 cycles, done at +6.
  - Required: grant0 and mem_req next edge; mem_addr = 0x123456, mem_rw = 1; done0 pulses one cycle; grant0 falls with done.
- Simultaneous requests:
  - Stimulus: req0 and req1 high together, both re-requesting after every done.
  - Required: grants alternate 0,1,0,1 and never overlap; each port is locked out for one cycle after its done.
- Background refresh:
  - Stimulus: REFRESH_INTERVAL = 50, no client requests.
  - Required: refresh_pending goes 0 -> 1 at cycle 50; mem_req with mem_refresh = 1 the next cycle; pending returns to 0 on mem_ack.
- Forced refresh:
  - Stimulus: req0 held continuously, pending reaches MAX_PENDING = 4.
  - Required: the next IDLE decision issues a refresh before port 0. Once pending drops to 3, port 0 wins again ahead of refresh.
- Overrun:
  - Stimulus: mem_ack held low with pending at 4, let another tick occur.
  - Required: pending stays at 4 and refresh_overrun = 1. A tick coinciding with a refresh ack leaves pending unchanged.
- Reset in WAIT_DONE:
  - Stimulus: during a port 1 write, assert RESET_n low.
  - Required: grant1 = 0, mem_req = 0, no done1 pulse, pending = 0. After release, port 0 wins the first tie.

Source files
------------

// File: rtl/ram_port_scheduler.sv
// Arbitrates the shared SDRAM command sequencer between two client ports
// and a locally timed auto-refresh engine with a banked refresh backlog.
module ram_port_scheduler #(
    parameter int REFRESH_INTERVAL = 50,
    parameter int MAX_PENDING      = 4
) (
    input  logic        CLK,
    input  logic        RESET_n,
    input  logic        req0,
    input  logic        req1,
    input  logic [22:0] addr0,
    input  logic [22:0] addr1,
    input  logic        rw0,
    input  logic        rw1,
    input  logic        uds0_n,
    input  logic        lds0_n,
    input  logic        uds1_n,
    input  logic        lds1_n,
    output logic        grant0,
    output logic        grant1,
    output logic        done0,
    output logic        done1,
    output logic        mem_req,
    output logic        mem_refresh,
    output logic [22:0] mem_addr,
    output logic        mem_rw,
    output logic        mem_uds_n,
    output logic        mem_lds_n,
    input  logic        mem_ack,
    input  logic        mem_done,
    output logic [2:0]  refresh_pending,
    output logic        refresh_overrun
);

    localparam int CW = $clog2(REFRESH_INTERVAL);
    localparam logic [CW-1:0] RELOAD = CW'(REFRESH_INTERVAL - 1);
    localparam logic [2:0] PMAX = 3'(MAX_PENDING);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_DONE
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [CW-1:0] ivl_cnt;
    logic          tick;
    logic          ref_ack;
    logic          at_max;
    logic          last_grant;
    logic          elig0;
    logic          elig1;
    logic          pick_ref;
    logic          pick0;
    logic          pick1;

    // IDLE decision: forced refresh, then clients (round-robin), then idle refresh
    always_comb begin
        tick     = (ivl_cnt == '0);
        ref_ack  = (state == ISSUE) && mem_ack && mem_refresh;
        at_max   = (refresh_pending == PMAX);
        // a port that just saw its done pulse sits out one IDLE cycle
        elig0    = req0 && !done0;
        elig1    = req1 && !done1;
        pick_ref = 1'b0;
        pick0    = 1'b0;
        pick1    = 1'b0;
        if (state == IDLE) begin
            if (at_max) begin
                pick_ref = 1'b1;
            end else if (elig0 && elig1) begin
                if (last_grant) pick0 = 1'b1;
                else            pick1 = 1'b1;
            end else if (elig0) begin
                pick0 = 1'b1;
            end else if (elig1) begin
                pick1 = 1'b1;
            end else if (refresh_pending != 3'd0) begin
                pick_ref = 1'b1;
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:      if (pick_ref || pick0 || pick1) state_nx = ISSUE;
            ISSUE:     if (mem_ack) state_nx = WAIT_DONE;
            WAIT_DONE: if (mem_done) state_nx = IDLE;
            default:   state_nx = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) state <= IDLE;
        else          state <= state_nx;
    end

    // Refresh interval timer: free-running down-counter with auto-reload
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n)  ivl_cnt <= RELOAD;
        else if (tick) ivl_cnt <= RELOAD;
        else           ivl_cnt <= ivl_cnt - CW'(1);
    end

    // Refresh backlog: ticks add, refresh acks subtract, saturation is sticky-flagged
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            refresh_pending <= 3'd0;
            refresh_overrun <= 1'b0;
        end else if (tick && !ref_ack) begin
            if (at_max) refresh_overrun <= 1'b1;
            else        refresh_pending <= refresh_pending + 3'd1;
        end else if (ref_ack && !tick) begin
            refresh_pending <= refresh_pending - 3'd1;
        end
    end

    // Grants, request handshake, latched payload and done pulses
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            grant0      <= 1'b0;
            grant1      <= 1'b0;
            done0       <= 1'b0;
            done1       <= 1'b0;
            mem_req     <= 1'b0;
            mem_refresh <= 1'b0;
            mem_addr    <= 23'd0;
            mem_rw      <= 1'b1;
            mem_uds_n   <= 1'b1;
            mem_lds_n   <= 1'b1;
            last_grant  <= 1'b1;
        end else begin
            done0 <= 1'b0;
            done1 <= 1'b0;
            if (pick0) begin
                grant0      <= 1'b1;
                last_grant  <= 1'b0;
                mem_req     <= 1'b1;
                mem_refresh <= 1'b0;
                mem_addr    <= addr0;
                mem_rw      <= rw0;
                mem_uds_n   <= uds0_n;
                mem_lds_n   <= lds0_n;
            end
            if (pick1) begin
                grant1      <= 1'b1;
                last_grant  <= 1'b1;
                mem_req     <= 1'b1;
                mem_refresh <= 1'b0;
                mem_addr    <= addr1;
                mem_rw      <= rw1;
                mem_uds_n   <= uds1_n;
                mem_lds_n   <= lds1_n;
            end
            if (pick_ref) begin
                mem_req     <= 1'b1;
                mem_refresh <= 1'b1;
            end
            if (state == ISSUE && mem_ack) begin
                mem_req <= 1'b0;
            end
            if (state == WAIT_DONE && mem_done) begin
                done0       <= grant0;
                done1       <= grant1;
                grant0      <= 1'b0;
                grant1      <= 1'b0;
                mem_refresh <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ram_port_scheduler.sv
// Directed bench for ram_port_scheduler: cycle vector table for client
// arbitration plus hand sequences for refresh, overrun and reset.
module tb_ram_port_scheduler;

    logic        CLK = 1'b0;
    logic        RESET_n = 1'b1;
    logic        req0 = 0, req1 = 0;
    logic [22:0] addr0 = 0, addr1 = 0;
    logic        rw0 = 1, rw1 = 1;
    logic        uds0_n = 1, lds0_n = 1, uds1_n = 1, lds1_n = 1;
    logic        grant0, grant1, done0, done1;
    logic        mem_req, mem_refresh;
    logic [22:0] mem_addr;
    logic        mem_rw, mem_uds_n, mem_lds_n;
    logic        mem_ack = 0, mem_done = 0;
    logic [2:0]  refresh_pending;
    logic        refresh_overrun;

    int checks = 0;
    int errors = 0;
    int ecount;

    localparam logic [22:0] P0 = 23'h123456;
    localparam logic [22:0] P1 = 23'h00ABCD;
    localparam logic [22:0] PX = 23'h7FFFFF;

    ram_port_scheduler #(
        .REFRESH_INTERVAL(50),
        .MAX_PENDING(4)
    ) dut (
        .CLK(CLK), .RESET_n(RESET_n),
        .req0(req0), .req1(req1),
        .addr0(addr0), .addr1(addr1),
        .rw0(rw0), .rw1(rw1),
        .uds0_n(uds0_n), .lds0_n(lds0_n),
        .uds1_n(uds1_n), .lds1_n(lds1_n),
        .grant0(grant0), .grant1(grant1),
        .done0(done0), .done1(done1),
        .mem_req(mem_req), .mem_refresh(mem_refresh),
        .mem_addr(mem_addr), .mem_rw(mem_rw),
        .mem_uds_n(mem_uds_n), .mem_lds_n(mem_lds_n),
        .mem_ack(mem_ack), .mem_done(mem_done),
        .refresh_pending(refresh_pending),
        .refresh_overrun(refresh_overrun)
    );

    always #5 CLK = ~CLK;

    // Rising edges since reset release; refresh ticks land on multiples of 50
    always @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) ecount <= 0;
        else          ecount <= ecount + 1;
    end

    // Mutual exclusion of grant0, grant1 and mem_refresh
    always @(negedge CLK) begin
        if (RESET_n) begin
            checks++;
            if ($countones({grant0, grant1, mem_refresh}) > 1) begin
                errors++;
                $display("FAIL exclusive: g0=%0b g1=%0b ref=%0b required at most one",
                         grant0, grant1, mem_refresh);
            end
        end
    end

    typedef struct {
        logic        r0, r1, ack, dn;
        logic [22:0] a0;
        logic [5:0]  exp;
        logic        psel;
    } vec_t;

    vec_t vt [31];

    task automatic sv(input int i, input logic r0, input logic r1,
                      input logic ak, input logic dn,
                      input logic [22:0] a0, input logic [5:0] e,
                      input logic ps);
        vt[i].r0 = r0; vt[i].r1 = r1; vt[i].ack = ak; vt[i].dn = dn;
        vt[i].a0 = a0; vt[i].exp = e; vt[i].psel = ps;
    endtask

    task automatic chk(input string n, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", n, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic run_to(input int n);
        for (int k = 0; k < 1000 && ecount < n; k++) cyc();
        chk("run_to", ecount, n);
    endtask

    task automatic do_reset();
        RESET_n = 1'b0;
        req0 = 0; req1 = 0; mem_ack = 0; mem_done = 0;
        cyc();
        RESET_n = 1'b1;
    endtask

    function automatic logic [5:0] outs();
        return {grant0, grant1, mem_req, mem_refresh, done0, done1};
    endfunction

    initial begin
        // {g0,g1,mem_req,mem_refresh,done0,done1}; psel 0 = port0 payload
        sv(0,  1,0,0,0, P0, 6'b101000, 0);
        sv(1,  1,0,0,0, PX, 6'b101000, 0);
        sv(2,  1,0,1,0, PX, 6'b100000, 0);
        sv(3,  0,0,0,0, PX, 6'b100000, 0);
        sv(4,  0,0,0,0, PX, 6'b100000, 0);
        sv(5,  0,0,0,0, PX, 6'b100000, 0);
        sv(6,  0,0,0,1, PX, 6'b000010, 0);
        sv(7,  0,0,0,0, P0, 6'b000000, 0);
        sv(8,  1,1,0,0, P0, 6'b011000, 1);
        sv(9,  1,1,1,0, P0, 6'b010000, 1);
        sv(10, 1,1,0,1, P0, 6'b000001, 1);
        sv(11, 1,1,0,0, P0, 6'b101000, 0);
        sv(12, 1,1,1,0, P0, 6'b100000, 0);
        sv(13, 1,1,0,1, P0, 6'b000010, 0);
        sv(14, 1,1,0,0, P0, 6'b011000, 1);
        sv(15, 1,1,1,0, P0, 6'b010000, 1);
        sv(16, 1,1,0,1, P0, 6'b000001, 1);
        sv(17, 1,0,0,0, P0, 6'b101000, 0);
        sv(18, 1,0,1,0, P0, 6'b100000, 0);
        sv(19, 1,0,0,1, P0, 6'b000010, 0);
        sv(20, 1,0,0,0, P0, 6'b000000, 0);
        sv(21, 1,0,0,0, P0, 6'b101000, 0);
        sv(22, 1,0,1,0, P0, 6'b100000, 0);
        sv(23, 0,0,0,1, P0, 6'b000010, 0);
        sv(24, 0,0,0,0, P0, 6'b000000, 0);
        sv(25, 0,0,0,1, P0, 6'b000000, 0);
        sv(26, 0,1,0,0, P0, 6'b011000, 1);
        sv(27, 0,1,0,1, P0, 6'b011000, 1);
        sv(28, 0,1,1,0, P0, 6'b010000, 1);
        sv(29, 0,1,0,1, P0, 6'b000001, 1);
        sv(30, 0,0,0,0, P0, 6'b000000, 1);

        #1 RESET_n = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        chk("rst_outs", outs(), 6'b000000);
        chk("rst_payload", {mem_rw, mem_uds_n, mem_lds_n, mem_addr},
            {3'b111, 23'd0});
        chk("rst_pending", {refresh_overrun, refresh_pending}, 4'd0);
        RESET_n = 1'b1;
        addr1 = P1; rw1 = 0; uds1_n = 0; lds1_n = 1;
        rw0 = 1; uds0_n = 0; lds0_n = 0;

        for (int i = 0; i < 31; i++) begin
            req0 = vt[i].r0; req1 = vt[i].r1;
            mem_ack = vt[i].ack; mem_done = vt[i].dn;
            addr0 = vt[i].a0;
            cyc();
            chk($sformatf("vec%0d_outs", i), outs(), vt[i].exp);
            chk($sformatf("vec%0d_payload", i), {mem_rw, mem_addr},
                vt[i].psel ? {1'b0, P1} : {1'b1, P0});
        end
        req0 = 0; req1 = 0; mem_ack = 0; mem_done = 0; addr0 = P0;

        // Background refresh from a clean timer phase
        do_reset();
        run_to(49);
        chk("bg_pend49", refresh_pending, 3'd0);
        cyc();
        chk("bg_pend50", {mem_req, refresh_pending}, {1'b0, 3'd1});
        cyc();
        chk("bg_issue", outs(), 6'b001100);
        mem_ack = 1; cyc(); mem_ack = 0;
        chk("bg_ack", {mem_req, mem_refresh, refresh_pending}, {2'b01, 3'd0});
        mem_done = 1; cyc(); mem_done = 0;
        chk("bg_done", outs(), 6'b000000);

        // Forced refresh: backlog fills while port 1 holds the controller
        req1 = 1; cyc();
        chk("fr_g1", outs(), 6'b011000);
        mem_ack = 1; cyc(); mem_ack = 0;
        req0 = 1;
        run_to(250);
        chk("fr_full", {grant1, refresh_pending}, {1'b1, 3'd4});
        mem_done = 1; cyc(); mem_done = 0; req1 = 0;
        chk("fr_d1", outs(), 6'b000001);
        cyc();
        chk("fr_ref_first", outs(), 6'b001100);
        mem_ack = 1; cyc(); mem_ack = 0;
        chk("fr_pend3", refresh_pending, 3'd3);
        mem_done = 1; cyc(); mem_done = 0;
        cyc();
        chk("fr_g0_wins", outs(), 6'b101000);
        chk("fr_addr", mem_addr, P0);
        mem_ack = 1; cyc(); mem_ack = 0;
        mem_done = 1; cyc(); mem_done = 0; req0 = 0;
        chk("fr_d0", outs(), 6'b000010);

        // Overrun: a refresh stalled without ack while ticks keep coming
        do_reset();
        run_to(249);
        chk("ov_pre", {refresh_overrun, refresh_pending, mem_req},
            {1'b0, 3'd4, 1'b1});
        cyc();
        chk("ov_set", {refresh_overrun, refresh_pending}, {1'b1, 3'd4});
        run_to(299);
        mem_ack = 1; cyc(); mem_ack = 0;
        chk("ov_tick_ack", {refresh_overrun, refresh_pending, mem_req},
            {1'b1, 3'd4, 1'b0});
        mem_done = 1; cyc(); mem_done = 0;
        cyc();
        chk("ov_forced", outs(), 6'b001100);
        mem_ack = 1; cyc(); mem_ack = 0;
        chk("ov_pend3", {refresh_overrun, refresh_pending}, {1'b1, 3'd3});

        // Reset while a port 1 write waits for completion
        do_reset();
        req1 = 1; cyc();
        chk("rw_g1", {grant1, mem_rw, mem_uds_n, mem_lds_n}, 4'b1001);
        mem_ack = 1; cyc(); mem_ack = 0;
        run_to(60);
        chk("rw_wait", {grant1, mem_req, refresh_pending}, {2'b10, 3'd1});
        RESET_n = 1'b0;
        #1;
        chk("rw_rst", {grant1, mem_req, done1, refresh_pending}, 6'd0);
        mem_done = 1; cyc(); mem_done = 0;
        chk("rw_no_done", {done1, grant1}, 2'b00);
        cyc();
        RESET_n = 1'b1;
        req0 = 1; req1 = 1;
        cyc();
        chk("rw_tie", outs(), 6'b101000);
        req0 = 0; req1 = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
